// File: rtl/sipp_pkg.sv
// Shared types and widths for the SIPP memory-port arbiter.
// The grant_t encoding identifies which client last owned the memory port.
package sipp_pkg;

    localparam int SIPP_ADDR_WIDTH = 8;
    localparam int SIPP_DATA_WIDTH = 16;

    // Request/grant vector bit positions
    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/sipp_rr_arb2.sv
// Two-input round-robin arbiter: one-hot combinational grant, registered last winner.
// On a tie the client that did not win most recently is granted.
module sipp_rr_arb2
    import sipp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output grant_t     last_grant
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_grant == FETCH) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Idle cycles leave the record untouched so fairness survives gaps
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= FETCH;
        end else if (|gnt) begin
            last_grant <= gnt[REQ_DATA] ? DATA : FETCH;
        end
    end

endmodule

// File: rtl/sipp_mem_arbiter.sv
// Arbitrates the SIPP fetch and load/store clients onto the single-port memory,
// returning registered read data one cycle after each grant.
module sipp_mem_arbiter
    import sipp_pkg::*;
#(
    parameter int ADDR_WIDTH = SIPP_ADDR_WIDTH,
    parameter int DATA_WIDTH = SIPP_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rsp_valid,
    output logic [DATA_WIDTH-1:0] d_rsp_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic [DATA_WIDTH-1:0] mem_r_data
);

    logic [1:0]            req;
    logic [1:0]            gnt;
    grant_t                last_grant;
    logic                  if_vld_p1;
    logic                  d_vld_p1;
    logic [DATA_WIDTH-1:0] if_data_p1;
    logic [DATA_WIDTH-1:0] d_data_p1;

    assign req[REQ_FETCH] = if_req;
    assign req[REQ_DATA]  = d_req;

    sipp_rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .en         (~rst),
        .req        (req),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    assign if_gnt = gnt[REQ_FETCH];
    assign d_gnt  = gnt[REQ_DATA];

    // Stage p0: drive the memory port from the granted client
    always_comb begin
        mem_addr   = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_w_data = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
            mem_rd   = 1'b1;
        end else if (d_gnt) begin
            mem_addr   = d_addr;
            mem_rd     = ~d_we;
            mem_wr     = d_we;
            mem_w_data = d_wdata;
        end
    end

    // Stage p1: capture the response for whichever client was granted
    always_ff @(posedge clk) begin
        if (rst) begin
            if_vld_p1  <= 1'b0;
            d_vld_p1   <= 1'b0;
            if_data_p1 <= '0;
            d_data_p1  <= '0;
        end else begin
            if_vld_p1 <= if_gnt;
            d_vld_p1  <= d_gnt;
            if (if_gnt) begin
                if_data_p1 <= mem_r_data;
            end
            if (d_gnt) begin
                d_data_p1 <= d_we ? '0 : mem_r_data;
            end
        end
    end

    // A reset arriving in the response cycle cancels that response
    assign if_rsp_valid = if_vld_p1 & ~rst;
    assign d_rsp_valid  = d_vld_p1 & ~rst;
    assign if_rsp_data  = if_data_p1;
    assign d_rsp_data   = d_data_p1;

    a_gnt_onehot : assert property (@(posedge clk) !(if_gnt && d_gnt));

    a_rr_tie : assert property (@(posedge clk) disable iff (rst)
        (req == 2'b11) |-> (d_gnt == (last_grant == FETCH)));

endmodule

// File: tb/tb_sipp_mem_arbiter.sv
// Self-checking bench for sipp_mem_arbiter: directed vector table followed by
// constrained-random traffic checked against a behavioural model of the arbiter.
module tb_sipp_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = '0;
    logic        if_gnt;
    logic        if_rsp_valid;
    logic [15:0] if_rsp_data;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_gnt;
    logic        d_rsp_valid;
    logic [15:0] d_rsp_data;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_w_data;
    logic [15:0] mem_r_data;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sipp_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_w_data   (mem_w_data),
        .mem_r_data   (mem_r_data)
    );

    // Power-up memory contents; location 0x10 is preset for the fetch test
    function automatic logic [15:0] init_word(logic [7:0] a);
        if (a == 8'h10) return 16'h1234;
        return {a, ~a} ^ 16'h3C5A;
    endfunction

    // Memory attached to the DUT: combinational read, write on the clock edge
    logic [15:0] tb_mem [256];
    bit          written [256];

    assign mem_r_data = written[mem_addr] ? tb_mem[mem_addr] : init_word(mem_addr);

    always @(posedge clk) begin
        if (mem_wr) begin
            tb_mem[mem_addr]  <= mem_w_data;
            written[mem_addr] <= 1'b1;
        end
    end

    // Reference model state
    logic [15:0] ref_mem [256];
    bit          data_won_last = 1'b0;
    bit          data_known = 1'b0;
    logic        exp_iv = 1'b0;
    logic        exp_dv = 1'b0;
    logic [15:0] exp_id = '0;
    logic [15:0] exp_dd = '0;
    logic        exp_ig;
    logic        exp_dg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic model_check();
        logic [7:0]  e_addr;
        logic [15:0] e_wd;
        exp_ig = 1'b0;
        exp_dg = 1'b0;
        if (!rst) begin
            if (if_req && d_req) begin
                exp_ig = data_won_last;
                exp_dg = !data_won_last;
            end else begin
                exp_ig = if_req;
                exp_dg = d_req;
            end
        end
        e_addr = exp_ig ? if_addr : (exp_dg ? d_addr : 8'h00);
        e_wd   = exp_dg ? d_wdata : 16'h0000;
        chk("if_gnt", {31'b0, if_gnt}, {31'b0, exp_ig});
        chk("d_gnt", {31'b0, d_gnt}, {31'b0, exp_dg});
        chk("mem_addr", {24'b0, mem_addr}, {24'b0, e_addr});
        chk("mem_rd", {31'b0, mem_rd}, {31'b0, exp_ig | (exp_dg & !d_we)});
        chk("mem_wr", {31'b0, mem_wr}, {31'b0, exp_dg & d_we});
        chk("mem_w_data", {16'b0, mem_w_data}, {16'b0, e_wd});
        chk("if_rsp_valid", {31'b0, if_rsp_valid}, {31'b0, exp_iv & !rst});
        chk("d_rsp_valid", {31'b0, d_rsp_valid}, {31'b0, exp_dv & !rst});
        if (data_known) begin
            chk("if_rsp_data", {16'b0, if_rsp_data}, {16'b0, exp_id});
            chk("d_rsp_data", {16'b0, d_rsp_data}, {16'b0, exp_dd});
        end
        // Advance the model to what the next cycle should show
        if (rst) begin
            exp_iv = 1'b0;
            exp_dv = 1'b0;
            exp_id = '0;
            exp_dd = '0;
            data_won_last = 1'b0;
            data_known = 1'b1;
        end else begin
            exp_iv = exp_ig;
            exp_dv = exp_dg;
            if (exp_ig) exp_id = ref_mem[if_addr];
            if (exp_dg) begin
                if (d_we) begin
                    exp_dd = '0;
                    ref_mem[d_addr] = d_wdata;
                end else begin
                    exp_dd = ref_mem[d_addr];
                end
            end
            if (exp_ig || exp_dg) data_won_last = exp_dg;
        end
    endtask

    typedef struct {
        bit        rst, ir;
        bit [7:0]  ia;
        bit        dr, dwe;
        bit [7:0]  da;
        bit [15:0] dwd;
        bit        ig, dg, iv;
        bit [15:0] id;
        bit        dv;
        bit [15:0] dd;
        bit        cd;
    } vec_t;

    function automatic vec_t mk(bit r, bit ir, bit [7:0] ia, bit dr, bit dwe, bit [7:0] da,
                                bit [15:0] dwd, bit ig, bit dg, bit iv, bit [15:0] id,
                                bit dv, bit [15:0] dd, bit cd);
        vec_t v;
        v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.ig = ig; v.dg = dg; v.iv = iv; v.id = id; v.dv = dv; v.dd = dd; v.cd = cd;
        return v;
    endfunction

    vec_t vecs [22];

    initial begin
        bit if_wait;
        bit d_wait;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));

        //           rst ir ia    dr we da    wdata    | ig dg iv id       dv dd       cd
        vecs[0]  = mk(1, 1, 8'h10, 1, 0, 8'h20, 16'h0,    0, 0, 0, 16'h0,    0, 16'h0,    0);
        vecs[1]  = mk(1, 1, 8'h10, 1, 0, 8'h20, 16'h0,    0, 0, 0, 16'h0,    0, 16'h0,    1);
        vecs[2]  = mk(0, 1, 8'h10, 0, 0, 8'h00, 16'h0,    1, 0, 0, 16'h0,    0, 16'h0,    1);
        vecs[3]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 16'h0,    0, 0, 1, 16'h1234, 0, 16'h0,    1);
        vecs[4]  = mk(0, 0, 8'h00, 1, 1, 8'h20, 16'hBEEF, 0, 1, 0, 16'h1234, 0, 16'h0,    1);
        vecs[5]  = mk(0, 0, 8'h00, 1, 0, 8'h20, 16'h0,    0, 1, 0, 16'h1234, 1, 16'h0,    1);
        vecs[6]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 16'h0,    0, 0, 0, 16'h1234, 1, 16'hBEEF, 1);
        vecs[7]  = mk(1, 1, 8'h10, 1, 0, 8'h20, 16'h0,    0, 0, 0, 16'h1234, 0, 16'hBEEF, 1);
        vecs[8]  = mk(0, 1, 8'h10, 1, 0, 8'h20, 16'h0,    0, 1, 0, 16'h0,    0, 16'h0,    1);
        vecs[9]  = mk(0, 1, 8'h10, 1, 0, 8'h20, 16'h0,    1, 0, 0, 16'h0,    1, 16'hBEEF, 1);
        vecs[10] = mk(0, 1, 8'h10, 1, 0, 8'h20, 16'h0,    0, 1, 1, 16'h1234, 0, 16'hBEEF, 1);
        vecs[11] = mk(0, 1, 8'h10, 1, 0, 8'h20, 16'h0,    1, 0, 0, 16'h1234, 1, 16'hBEEF, 1);
        vecs[12] = mk(0, 1, 8'h10, 1, 0, 8'h20, 16'h0,    0, 1, 1, 16'h1234, 0, 16'hBEEF, 1);
        vecs[13] = mk(0, 1, 8'h10, 1, 0, 8'h20, 16'h0,    1, 0, 0, 16'h1234, 1, 16'hBEEF, 1);
        vecs[14] = mk(0, 0, 8'h00, 0, 0, 8'h00, 16'h0,    0, 0, 1, 16'h1234, 0, 16'hBEEF, 1);
        vecs[15] = mk(0, 0, 8'h00, 1, 1, 8'h30, 16'h5A5A, 0, 1, 0, 16'h1234, 0, 16'hBEEF, 1);
        vecs[16] = mk(0, 1, 8'h30, 0, 0, 8'h00, 16'h0,    1, 0, 0, 16'h1234, 1, 16'h0,    1);
        vecs[17] = mk(0, 0, 8'h00, 0, 0, 8'h00, 16'h0,    0, 0, 1, 16'h5A5A, 0, 16'h0,    1);
        vecs[18] = mk(0, 1, 8'h10, 0, 0, 8'h00, 16'h0,    1, 0, 0, 16'h5A5A, 0, 16'h0,    1);
        vecs[19] = mk(1, 1, 8'h10, 1, 0, 8'h20, 16'h0,    0, 0, 0, 16'h1234, 0, 16'h0,    1);
        vecs[20] = mk(0, 1, 8'h10, 1, 0, 8'h20, 16'h0,    0, 1, 0, 16'h0,    0, 16'h0,    1);
        vecs[21] = mk(0, 0, 8'h00, 0, 0, 8'h00, 16'h0,    0, 0, 0, 16'h0,    1, 16'hBEEF, 1);

        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            rst = vecs[i].rst; if_req = vecs[i].ir; if_addr = vecs[i].ia;
            d_req = vecs[i].dr; d_we = vecs[i].dwe; d_addr = vecs[i].da; d_wdata = vecs[i].dwd;
            @(negedge clk);
            chk("tbl_if_gnt", {31'b0, if_gnt}, {31'b0, vecs[i].ig});
            chk("tbl_d_gnt", {31'b0, d_gnt}, {31'b0, vecs[i].dg});
            chk("tbl_if_rsp_valid", {31'b0, if_rsp_valid}, {31'b0, vecs[i].iv});
            chk("tbl_d_rsp_valid", {31'b0, d_rsp_valid}, {31'b0, vecs[i].dv});
            if (vecs[i].cd) begin
                chk("tbl_if_rsp_data", {16'b0, if_rsp_data}, {16'b0, vecs[i].id});
                chk("tbl_d_rsp_data", {16'b0, d_rsp_data}, {16'b0, vecs[i].dd});
            end
            model_check();
            @(posedge clk);
            #1;
            cyc++;
        end

        // Random traffic; a pending request is usually held until granted
        if_wait = 1'b0;
        d_wait = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(40) == 0);
            if (!(if_wait && $urandom_range(7) != 0)) begin
                if_req  = ($urandom_range(3) != 0);
                if_addr = 8'($urandom_range(15));
            end
            if (!(d_wait && $urandom_range(7) != 0)) begin
                d_req   = ($urandom_range(3) != 0);
                d_we    = $urandom_range(1) != 0;
                d_addr  = 8'($urandom_range(15));
                d_wdata = 16'($urandom());
            end
            @(negedge clk);
            model_check();
            if_wait = if_req && !exp_ig && !rst;
            d_wait  = d_req && !exp_dg && !rst;
            @(posedge clk);
            #1;
            cyc++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sipp_mem_arbiter.md
Name: sipp_mem_arbiter

Overview:
- Sits directly upstream of the SIPP single-port memory (one address bus, combinational read, synchronous write).
- Arbitrates two SIPP clients onto that port, one access per cycle:
  - the instruction-fetch client, which only reads;
  - the data load/store client, which reads and writes.
- Uses request/grant handshakes with round-robin fairness. Read data is registered, so each client gets its response exactly one cycle after its grant.

Parameters:
- ADDR_WIDTH, 8, memory address width in bits.
- DATA_WIDTH, 16, memory data width in bits.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- if_req  input  1  fetch read request; held until if_gnt.
- if_addr  input  ADDR_WIDTH  fetch address.
- if_gnt  output  1  fetch granted this cycle (combinational).
- if_rsp_valid  output  1  fetch read data valid (registered).
- if_rsp_data  output  DATA_WIDTH  fetch read data.
- d_req  input  1  data access request; held until d_gnt.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_WIDTH  data address.
- d_wdata  input  DATA_WIDTH  write data.
- d_gnt  output  1  data client granted this cycle (combinational).
- d_rsp_valid  output  1  data response valid: read data, or write acknowledge.
- d_rsp_data  output  DATA_WIDTH  data read result; 0 on a write acknowledge.
- mem_addr  output  ADDR_WIDTH  to memory addr.
- mem_rd  output  1  to memory rd.
- mem_wr  output  1  to memory wr.
- mem_w_data  output  DATA_WIDTH  to memory w_data.
- mem_r_data  input  DATA_WIDTH  from memory r_data (combinational).

Behaviour:
- Reset:
  - While rst is high, if_gnt = d_gnt = 0 and mem_rd = mem_wr = 0; mem_addr and mem_w_data are 0.
  - On the reset edge, if_rsp_valid, d_rsp_valid, if_rsp_data and d_rsp_data are all cleared to 0.
  - last_grant resets to FETCH, so the data client wins the first tie.
- Arbitration (combinational, outside reset):
  - Only one request active: grant it.
  - Both active: grant the client not recorded in last_grant.
  - On every cycle that issues a grant, last_grant is updated to the granted client. It is unchanged on idle cycles.
  - At most one grant per cycle; if_gnt and d_gnt are never both 1.
- Memory drive in the granted cycle:
  - mem_addr = the granted client's address.
  - Fetch grant: mem_rd = 1.
  - Data grant: mem_rd = !d_we, mem_wr = d_we, mem_w_data = d_wdata.
  - No grant: mem_rd = mem_wr = 0, mem_addr = 0, mem_w_data = 0.
- Response path:
  - On the clock edge that ends a granted cycle, mem_r_data is captured into the granted client's rsp_data and that client's rsp_valid is set for exactly one cycle.
  - A data write sets d_rsp_valid = 1 with d_rsp_data = 0. Memory write latency is 1 edge, so the write is visible to any grant in the next cycle.
  - rsp_data holds its last value while rsp_valid = 0.
- Latency and throughput:
  - Grant to response is 1 cycle.
  - Back-to-back grants to the same client are allowed when the other client is idle, for a throughput of 1 access/cycle.
- Handshake rules:
  - A client may change address or data only in the cycle after its grant.
  - Deasserting req before grant withdraws the request; this is legal and has no side effects.
- Read-after-write:
  - A data write granted in cycle N followed by a fetch of the same address granted in cycle N+1 returns the new data.
- Reset mid-operation:
  - rst asserted in the cycle after a grant suppresses that response: rsp_valid stays 0.
  - Outstanding requests are not remembered; clients must re-request after reset.
- Starvation bound: with both requests held continuously, each client is granted at least every 2nd cycle.

Decomposition:
- Shared package sipp_pkg holds:
  - SIPP_ADDR_WIDTH = 8 and SIPP_DATA_WIDTH = 16;
  - a grant_t enum with values FETCH and DATA, used for last_grant.
- One sub-module: sipp_rr_arb2, a 2-input round-robin arbiter. It takes req[1:0], the update enable and rst, and returns a one-hot gnt[1:0] plus the registered last_grant. The mux, memory drive and response registers stay in the top level.

Test Plan:
- Reset: hold rst 2 cycles with if_req = d_req = 1 -> no grants, mem_rd = mem_wr = 0, both rsp_valid = 0.
- Fetch only: if_req with if_addr = 0x10, memory[0x10] = 0x1234 -> if_gnt in cycle 0; cycle 1 if_rsp_valid = 1 with if_rsp_data = 0x1234.
- Write then read-back: data write addr 0x20, wdata 0xBEEF, then data read addr 0x20 -> first response d_rsp_valid = 1 with data 0; next response d_rsp_data = 0xBEEF.
- Contention: both requests held 6 cycles after reset -> grants D, F, D, F, D, F; each rsp_valid pulses in the following cycle.
- RAW across clients: data write 0x30 = 0x5A5A granted cycle N, fetch of 0x30 granted cycle N+1 -> if_rsp_data = 0x5A5A in cycle N+2.
- Reset mid-flight: fetch granted cycle N, rst high in cycle N+1 -> if_rsp_valid stays 0, last_grant = FETCH, and the next tie grants data.
